// File: rtl/logic_unit_arbiter_if.sv
// logic_unit_arbiter_if: requester-side bus of the shared logic unit arbiter
interface logic_unit_arbiter_if #(parameter int NREQ = 4, parameter int WIDTH = 16);
   localparam int IW = $clog2(NREQ);
   logic [NREQ-1:0]       req;
   logic [2*NREQ-1:0]     op;
   logic [WIDTH*NREQ-1:0] a;
   logic [WIDTH*NREQ-1:0] b;
   logic [NREQ-1:0]       gnt;
   logic [NREQ-1:0]       done;
   logic [WIDTH-1:0]      result;
   logic [IW-1:0]         res_id;
   logic                  busy;
   modport master (output req, op, a, b, input gnt, done, result, res_id, busy);
   modport slave (input req, op, a, b, output gnt, done, result, res_id, busy);
endinterface

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin shared bitwise logic unit, grant then result two cycles after request
module logic_unit_arbiter #(parameter int NREQ = 4, parameter int WIDTH = 16) (
   input logic clk,
   input logic rst_n,
   logic_unit_arbiter_if.slave bus
);
   localparam int IW = $clog2(NREQ);
   localparam logic [NREQ-1:0] one = NREQ'(1);
   typedef enum logic {IDLE, EXEC} state_t;
   state_t state;
   logic [IW-1:0] ptr, k, win;
   logic [1:0] op_q;
   logic [WIDTH-1:0] a_q, b_q, f;
   logic [1:0] op_v [NREQ];
   logic [WIDTH-1:0] a_v [NREQ];
   logic [WIDTH-1:0] b_v [NREQ];
   function automatic logic [IW-1:0] wrap(input int v);
      return IW'(v % NREQ);
   endfunction
   // descending scan so the last hit is the first set bit at or above ptr
   always_comb begin
      win = '0;
      for (int i = NREQ - 1; i >= 0; i--)
         if (bus.req[wrap(int'(ptr) + i)]) win = wrap(int'(ptr) + i);
   end
   always_comb
      for (int i = 0; i < NREQ; i++) begin
         op_v[i] = bus.op[2*i +: 2];
         a_v[i] = bus.a[WIDTH*i +: WIDTH];
         b_v[i] = bus.b[WIDTH*i +: WIDTH];
      end
   assign f = op_q == 2'b00 ? a_q & b_q :
              op_q == 2'b01 ? ~(a_q & b_q) :
              op_q == 2'b10 ? a_q | b_q : a_q ^ b_q;
   assign bus.busy = state == EXEC;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         ptr <= '0;
         k <= '0;
         op_q <= '0;
         a_q <= '0;
         b_q <= '0;
         bus.gnt <= '0;
         bus.done <= '0;
         bus.result <= '0;
         bus.res_id <= '0;
      end else begin
         bus.done <= '0;
         if (state == IDLE) begin
            if (|bus.req) begin
               state <= EXEC;
               k <= win;
               op_q <= op_v[win];
               a_q <= a_v[win];
               b_q <= b_v[win];
               bus.gnt <= one << win;
            end
         end else begin
            state <= IDLE;
            bus.gnt <= '0;
            bus.done <= one << k;
            bus.result <= f;
            bus.res_id <= k;
            ptr <= wrap(int'(k) + 1);
         end
      end
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb_logic_unit_arbiter: directed table vectors plus multi-cycle corner sequences
module tb_logic_unit_arbiter;
   logic clk = 1'b0;
   logic rst_n;
   int nvec = 0;
   int nerr = 0;
   logic_unit_arbiter_if #(.NREQ(4), .WIDTH(16)) bus ();
   logic_unit_arbiter #(.NREQ(4), .WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
   always #5 clk = ~clk;
   typedef struct {
      logic [3:0]  req;
      int          lane;
      logic [1:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  gnt;
      logic [15:0] res;
   } vec_t;
   vec_t tv [5];
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask
   task automatic set_lane(input int i, input logic [1:0] o, input logic [15:0] av, input logic [15:0] bv);
      bus.op[2*i +: 2] = o;
      bus.a[16*i +: 16] = av;
      bus.b[16*i +: 16] = bv;
   endtask
   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
   initial begin
      tv[0] = '{4'b0001, 0, 2'b00, 16'hF0F0, 16'hFF00, 4'b0001, 16'hF000};
      tv[1] = '{4'b0010, 1, 2'b00, 16'hAAAA, 16'h00FF, 4'b0010, 16'h00AA};
      tv[2] = '{4'b0100, 2, 2'b01, 16'hAAAA, 16'h00FF, 4'b0100, 16'hFF55};
      tv[3] = '{4'b1000, 3, 2'b10, 16'hAAAA, 16'h00FF, 4'b1000, 16'hAAFF};
      tv[4] = '{4'b0001, 0, 2'b11, 16'hAAAA, 16'h00FF, 4'b0001, 16'hAA55};
      rst_n = 1'b0;
      bus.req = '0;
      bus.op = '0;
      bus.a = '0;
      bus.b = '0;
      #12;
      chk("rst_gnt", 32'(bus.gnt), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_result", 32'(bus.result), 0);
      chk("rst_res_id", 32'(bus.res_id), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      step();
      rst_n = 1'b1;
      step();
      chk("idle_gnt", 32'(bus.gnt), 0);
      for (int v = 0; v < 5; v++) begin
         for (int i = 0; i < 4; i++) set_lane(i, 2'b11, 16'hDEAD, 16'hBEEF);
         set_lane(tv[v].lane, tv[v].op, tv[v].a, tv[v].b);
         bus.req = tv[v].req;
         step();
         chk($sformatf("v%0d_gnt", v), 32'(bus.gnt), 32'(tv[v].gnt));
         chk($sformatf("v%0d_busy", v), 32'(bus.busy), 1);
         chk($sformatf("v%0d_done0", v), 32'(bus.done), 0);
         bus.req = '0;
         step();
         chk($sformatf("v%0d_done", v), 32'(bus.done), 32'(tv[v].gnt));
         chk($sformatf("v%0d_result", v), 32'(bus.result), 32'(tv[v].res));
         chk($sformatf("v%0d_res_id", v), 32'(bus.res_id), tv[v].lane);
         chk($sformatf("v%0d_gnt0", v), 32'(bus.gnt), 0);
         step();
         chk($sformatf("v%0d_hold", v), 32'(bus.result), 32'(tv[v].res));
         chk($sformatf("v%0d_done_pulse", v), 32'(bus.done), 0);
      end
      // ptr is 1 here; granting requester 1 moves it to 2
      bus.req = 4'b0010;
      step();
      chk("rr_pre_gnt", 32'(bus.gnt), 32'(4'b0010));
      bus.req = '0;
      step();
      bus.req = 4'b1010;
      step();
      chk("rr_first", 32'(bus.gnt), 32'(4'b1000));
      bus.req = 4'b0010;
      step();
      chk("rr_first_done", 32'(bus.done), 32'(4'b1000));
      step();
      chk("rr_second", 32'(bus.gnt), 32'(4'b0010));
      bus.req = '0;
      step();
      chk("rr_second_done", 32'(bus.done), 32'(4'b0010));
      set_lane(0, 2'b00, 16'h1234, 16'hFFFF);
      bus.req = 4'b0001;
      step();
      chk("cap_gnt", 32'(bus.gnt), 32'(4'b0001));
      bus.req = '0;
      set_lane(0, 2'b11, 16'hFFFF, 16'h0000);
      step();
      chk("cap_done", 32'(bus.done), 32'(4'b0001));
      chk("cap_result", 32'(bus.result), 32'(16'h1234));
      step();
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) set_lane(i, 2'b10, 16'(16'h1111 * (i + 1)), 16'h0000);
      bus.req = 4'b1111;
      step();
      rst_n = 1'b1;
      for (int g = 0; g < 5; g++) begin
         step();
         chk($sformatf("cont%0d_gnt", g), 32'(bus.gnt), 32'(4'b0001 << (g % 4)));
         chk($sformatf("cont%0d_nodone", g), 32'(bus.done), 0);
         step();
         chk($sformatf("cont%0d_done", g), 32'(bus.done), 32'(4'b0001 << (g % 4)));
         chk($sformatf("cont%0d_nognt", g), 32'(bus.gnt), 0);
         chk($sformatf("cont%0d_result", g), 32'(bus.result), 32'(16'(16'h1111 * ((g % 4) + 1))));
      end
      bus.req = 4'b0100;
      step();
      chk("ar_gnt", 32'(bus.gnt), 32'(4'b0100));
      chk("ar_busy", 32'(bus.busy), 1);
      bus.req = '0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_gnt0", 32'(bus.gnt), 0);
      chk("ar_done0", 32'(bus.done), 0);
      chk("ar_result0", 32'(bus.result), 0);
      chk("ar_busy0", 32'(bus.busy), 0);
      step();
      rst_n = 1'b1;
      step();
      chk("ar_no_done", 32'(bus.done), 0);
      chk("ar_idle_gnt", 32'(bus.gnt), 0);
      bus.req = 4'b1010;
      step();
      chk("ar_lowest", 32'(bus.gnt), 32'(4'b0010));
      bus.req = '0;
      step();
      chk("ar_lowest_done", 32'(bus.done), 32'(4'b0010));
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
